beta_pipe_ctrl_unit: RTL and testbench
======================================

Name: beta_pipe_ctrl_unit

Overview:
- Global Pipeline Control Unit: the producer side of the stall/flush interface consumed by the fetch/decode, decode/execute and execute/memory pipeline registers.
- Detects load-use hazards, taken branches, multi-cycle execute occupancy, data-memory back-pressure and illegal-instruction traps.
- Drives per-register stall/flush, a PC hold and a trap request.
- Sits beside the datapath; fully synchronous to the core clock.

Parameters:
TrapLatency, 3, cycles all pipeline registers stay flushed after a trap (1..15)
MaxBusyCycles, 64, execute-busy cycles before busy-timeout is flagged (2..255)
PerfWidth, 32, width of stall-cycle performance counter

Ports:
clk_i  in  1  core clock
rstn_i  in  1  asynchronous active-low reset
dec_rs1_addr_i  in  5  decode-stage source register 1
dec_rs2_addr_i  in  5  decode-stage source register 2
dec_rs1_used_i  in  1  instruction in decode reads rs1
dec_rs2_used_i  in  1  instruction in decode reads rs2
exe_rd_addr_i  in  5  destination register of instruction in execute
exe_is_load_i  in  1  instruction in execute is a load
exe_valid_i  in  1  execute holds a real (non-bubble) instruction
exe_invalid_instr_i  in  1  illegal-instruction flag from decode/execute register
exe_branch_taken_i  in  1  execute resolved a taken branch/jump
exe_busy_i  in  1  multi-cycle execute unit occupied
mem_stall_i  in  1  data memory not ready
pc_hold_o  out  1  fetch PC must not advance
fet_dec_stall_o / fet_dec_flush_o  out  1 each  fetch/decode register control
dec_exe_stall_o / dec_exe_flush_o  out  1 each  decode/execute register control
exe_mem_stall_o / exe_mem_flush_o  out  1 each  execute/memory register control
trap_req_o  out  1  one-cycle pulse: fetch loads trap vector
busy_timeout_o  out  1  one-cycle pulse on execute-busy watchdog expiry
stall_cycles_o  out  PerfWidth  count of cycles with any stall asserted

Behaviour:
- Rules apply to every cycle. Outputs are combinational from state and inputs. state, trap counter, busy counter and perf counter are registered.
- Any register with flush=1 has stall=0; flush wins.
- Reset (rstn_i=0, asynchronous): state=INIT, counters=0. While in reset, all three flush outputs=1. All other outputs=0.
- INIT: all flushes=1, pc_hold_o=1. The next cycle goes to RUN.
- Load-use hazard (luh) is true when all of the following hold:
  - exe_valid_i and exe_is_load_i
  - exe_rd_addr_i != 0
  - (rs1_used and rs1==rd) or (rs2_used and rs2==rd)
- RUN evaluation, strict priority; the first match applies:
  1. exe_valid_i and exe_invalid_instr_i: flush all three registers, trap_req_o=1, pc_hold_o=0. Trap counter loads TrapLatency-1. Go to TRAP.
  2. mem_stall_i: stall all three registers, pc_hold_o=1.
  3. exe_branch_taken_i: flush fet_dec and dec_exe, pc_hold_o=0 (execute redirects the PC). Taking a branch costs two bubbles.
  4. exe_busy_i: pc_hold_o=1, stall fet_dec and dec_exe, flush exe_mem. Busy counter=1. Go to MC_WAIT.
  5. luh: pc_hold_o=1, stall fet_dec, flush dec_exe (one bubble).
  6. Otherwise: all controls 0.
- MC_WAIT:
  - mem_stall_i=1: stall all three registers, pc_hold_o=1.
  - Else if exe_busy_i=1: same outputs as RUN rule 4. Busy counter increments, saturating at MaxBusyCycles. busy_timeout_o pulses once, in the cycle the counter reaches MaxBusyCycles.
  - Else if exe_busy_i=0: apply the RUN evaluation for that cycle, rules 1-3 and 5 (a trap or branch from the finishing instruction is honoured). Busy counter clears. Go to RUN, or to TRAP if rule 1 fired.
- TRAP:
  - All three flushes=1, pc_hold_o=0, trap_req_o=0. All hazard, branch and busy inputs are ignored.
  - Counter decrements. When counter==0, the next state is RUN.
  - TrapLatency=1 spends exactly one cycle in TRAP.
- stall_cycles_o increments when any *_stall_o=1, wrapping modulo 2^PerfWidth. INIT and TRAP cycles are not counted.
- Reset mid-operation (any state): returns immediately to INIT with the reset output values.

Decomposition:
- beta_pkg gains the following. The hazard compare stays inline.
  - typedef enum pctrl_state_t {PCTRL_INIT, PCTRL_RUN, PCTRL_MC_WAIT, PCTRL_TRAP}
  - struct pipe_ctrl_t {stall, flush}, one per pipeline register
  - REG_ZERO = 5'd0
- One sub-module: beta_pipe_hazard_det, a purely combinational luh detector reusable by a future forwarding unit.

Test Plan:
- Reset release, no activity: cycle 0 all flushes=1, pc_hold_o=1. Cycle 1 all controls 0, stall_cycles_o=0.
- Load-use: exe_valid=1, exe_is_load=1, rd=5, rs2=5 used, rs1=0 -> fet_dec_stall=1, dec_exe_flush=1, pc_hold=1 for 1 cycle. Repeating the stimulus with rd=0 -> no action.
- Branch and load-use together: branch_taken=1 with luh true -> fet_dec_flush=1, dec_exe_flush=1, fet_dec_stall=0, pc_hold=0.
- Busy 70 cycles, MaxBusyCycles=64 -> stall for 70 cycles, busy_timeout_o pulses once at busy cycle 64. Release on the drop cycle. stall_cycles_o=70.
- Illegal instruction with mem_stall_i=1 -> trap wins: trap_req_o=1 for one cycle, then all flushes=1 for 3 cycles (TrapLatency=3), then RUN. mem_stall is ignored during TRAP.
- rstn_i asserted in MC_WAIT -> outputs take reset values asynchronously. After release, the INIT sequence is repeated.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types for the beta core pipeline control: controller states, per-register
// stall/flush pair and the x0 register index.
package beta_pkg;

   typedef enum logic [1:0] {
      PCTRL_INIT,
      PCTRL_RUN,
      PCTRL_MC_WAIT,
      PCTRL_TRAP
   } pctrl_state_t;

   typedef struct packed {
      logic stall;
      logic flush;
   } pipe_ctrl_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A flushed register must never also be held, so flush always overrides stall.
   function automatic pipe_ctrl_t flush_wins(input pipe_ctrl_t c);
      pipe_ctrl_t r;
      r.flush = c.flush;
      r.stall = c.stall & ~c.flush;
      return r;
   endfunction

endpackage

// File: rtl/beta_pipe_ctrl_unit_if.sv
// Hazard inputs from the datapath and stall/flush/trap controls back to it.
// master = pipeline control unit, slave = datapath pipeline registers and fetch.
interface beta_pipe_ctrl_unit_if #(
   parameter int PerfWidth = 32
);
   logic [4:0]           dec_rs1_addr_i;
   logic [4:0]           dec_rs2_addr_i;
   logic                 dec_rs1_used_i;
   logic                 dec_rs2_used_i;
   logic [4:0]           exe_rd_addr_i;
   logic                 exe_is_load_i;
   logic                 exe_valid_i;
   logic                 exe_invalid_instr_i;
   logic                 exe_branch_taken_i;
   logic                 exe_busy_i;
   logic                 mem_stall_i;
   logic                 pc_hold_o;
   logic                 fet_dec_stall_o;
   logic                 fet_dec_flush_o;
   logic                 dec_exe_stall_o;
   logic                 dec_exe_flush_o;
   logic                 exe_mem_stall_o;
   logic                 exe_mem_flush_o;
   logic                 trap_req_o;
   logic                 busy_timeout_o;
   logic [PerfWidth-1:0] stall_cycles_o;

   modport master (
      input  dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_used_i, dec_rs2_used_i,
      input  exe_rd_addr_i, exe_is_load_i, exe_valid_i, exe_invalid_instr_i,
      input  exe_branch_taken_i, exe_busy_i, mem_stall_i,
      output pc_hold_o, fet_dec_stall_o, fet_dec_flush_o, dec_exe_stall_o,
      output dec_exe_flush_o, exe_mem_stall_o, exe_mem_flush_o,
      output trap_req_o, busy_timeout_o, stall_cycles_o
   );

   modport slave (
      output dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_used_i, dec_rs2_used_i,
      output exe_rd_addr_i, exe_is_load_i, exe_valid_i, exe_invalid_instr_i,
      output exe_branch_taken_i, exe_busy_i, mem_stall_i,
      input  pc_hold_o, fet_dec_stall_o, fet_dec_flush_o, dec_exe_stall_o,
      input  dec_exe_flush_o, exe_mem_stall_o, exe_mem_flush_o,
      input  trap_req_o, busy_timeout_o, stall_cycles_o
   );

endinterface

// File: rtl/beta_pipe_hazard_det.sv
// Combinational load-use hazard detector: the instruction in decode reads a register
// that a load currently in execute has not yet written back.
module beta_pipe_hazard_det
   import beta_pkg::*;
(
   input  logic [4:0] rs1_addr,
   input  logic [4:0] rs2_addr,
   input  logic       rs1_used,
   input  logic       rs2_used,
   input  logic [4:0] exe_rd_addr,
   input  logic       exe_is_load,
   input  logic       exe_valid,
   output logic       load_use
);

   logic rs1_match;
   logic rs2_match;

   // x0 is hardwired to zero, so a load targeting it can never create a hazard.
   assign rs1_match = rs1_used && (rs1_addr == exe_rd_addr);
   assign rs2_match = rs2_used && (rs2_addr == exe_rd_addr);
   assign load_use  = exe_valid && exe_is_load && (exe_rd_addr != REG_ZERO)
                      && (rs1_match || rs2_match);

endmodule

// File: rtl/beta_pipe_ctrl_unit.sv
// Global pipeline control: turns hazard, branch, busy, back-pressure and trap events
// into per-register stall/flush, PC hold and trap request, plus a stall-cycle counter.
module beta_pipe_ctrl_unit
   import beta_pkg::*;
#(
   parameter int TrapLatency   = 3,
   parameter int MaxBusyCycles = 64,
   parameter int PerfWidth     = 32
) (
   input logic                  clk_i,
   input logic                  rstn_i,
   beta_pipe_ctrl_unit_if.master ctrl
);

   localparam logic [3:0] TrapLoad = 4'(TrapLatency - 1);
   localparam logic [7:0] BusyMax  = 8'(MaxBusyCycles);

   pctrl_state_t         state_q, state_d;
   logic [3:0]           trap_cnt_q, trap_cnt_d;
   logic [7:0]           busy_cnt_q, busy_cnt_d;
   logic [PerfWidth-1:0] perf_cnt_q;

   pipe_ctrl_t fd_raw, de_raw, em_raw;
   pipe_ctrl_t fd, de, em;
   logic       pc_hold, trap_req, busy_timeout;
   logic       luh, trap_hit, any_stall;

   beta_pipe_hazard_det u_hazard (
      .rs1_addr    (ctrl.dec_rs1_addr_i),
      .rs2_addr    (ctrl.dec_rs2_addr_i),
      .rs1_used    (ctrl.dec_rs1_used_i),
      .rs2_used    (ctrl.dec_rs2_used_i),
      .exe_rd_addr (ctrl.exe_rd_addr_i),
      .exe_is_load (ctrl.exe_is_load_i),
      .exe_valid   (ctrl.exe_valid_i),
      .load_use    (luh)
   );

   assign trap_hit = ctrl.exe_valid_i && ctrl.exe_invalid_instr_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= PCTRL_INIT;
         trap_cnt_q <= '0;
         busy_cnt_q <= '0;
         perf_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         trap_cnt_q <= trap_cnt_d;
         busy_cnt_q <= busy_cnt_d;
         if (any_stall && state_q != PCTRL_INIT && state_q != PCTRL_TRAP) begin
            perf_cnt_q <= perf_cnt_q + 1'b1;
         end
      end
   end

   // MC_WAIT shares the RUN priority chain once the multi-cycle unit lets go, so a trap
   // or branch raised by the finishing instruction is not lost.
   always_comb begin
      state_d      = state_q;
      trap_cnt_d   = trap_cnt_q;
      busy_cnt_d   = busy_cnt_q;
      fd_raw       = '0;
      de_raw       = '0;
      em_raw       = '0;
      pc_hold      = 1'b0;
      trap_req     = 1'b0;
      busy_timeout = 1'b0;

      unique case (state_q)
         PCTRL_INIT: begin
            fd_raw.flush = 1'b1;
            de_raw.flush = 1'b1;
            em_raw.flush = 1'b1;
            pc_hold      = 1'b1;
            state_d      = PCTRL_RUN;
         end

         PCTRL_RUN, PCTRL_MC_WAIT: begin
            if (state_q == PCTRL_MC_WAIT && ctrl.mem_stall_i) begin
               fd_raw.stall = 1'b1;
               de_raw.stall = 1'b1;
               em_raw.stall = 1'b1;
               pc_hold      = 1'b1;
            end else if (state_q == PCTRL_MC_WAIT && ctrl.exe_busy_i) begin
               fd_raw.stall = 1'b1;
               de_raw.stall = 1'b1;
               em_raw.flush = 1'b1;
               pc_hold      = 1'b1;
               if (busy_cnt_q < BusyMax) begin
                  busy_cnt_d   = busy_cnt_q + 8'd1;
                  busy_timeout = (busy_cnt_q == BusyMax - 8'd1);
               end
            end else begin
               state_d    = PCTRL_RUN;
               busy_cnt_d = '0;
               if (trap_hit) begin
                  fd_raw.flush = 1'b1;
                  de_raw.flush = 1'b1;
                  em_raw.flush = 1'b1;
                  trap_req     = 1'b1;
                  trap_cnt_d   = TrapLoad;
                  state_d      = PCTRL_TRAP;
               end else if (ctrl.mem_stall_i) begin
                  fd_raw.stall = 1'b1;
                  de_raw.stall = 1'b1;
                  em_raw.stall = 1'b1;
                  pc_hold      = 1'b1;
               end else if (ctrl.exe_branch_taken_i) begin
                  fd_raw.flush = 1'b1;
                  de_raw.flush = 1'b1;
               end else if (state_q == PCTRL_RUN && ctrl.exe_busy_i) begin
                  fd_raw.stall = 1'b1;
                  de_raw.stall = 1'b1;
                  em_raw.flush = 1'b1;
                  pc_hold      = 1'b1;
                  busy_cnt_d   = 8'd1;
                  state_d      = PCTRL_MC_WAIT;
               end else if (luh) begin
                  fd_raw.stall = 1'b1;
                  de_raw.flush = 1'b1;
                  pc_hold      = 1'b1;
               end
            end
         end

         PCTRL_TRAP: begin
            fd_raw.flush = 1'b1;
            de_raw.flush = 1'b1;
            em_raw.flush = 1'b1;
            if (trap_cnt_q == 4'd0) begin
               state_d = PCTRL_RUN;
            end else begin
               trap_cnt_d = trap_cnt_q - 4'd1;
            end
         end

         default: state_d = PCTRL_INIT;
      endcase

      fd = flush_wins(fd_raw);
      de = flush_wins(de_raw);
      em = flush_wins(em_raw);

      // While reset is held the pipeline is flushed but fetch is not told to hold.
      if (!rstn_i) begin
         fd           = '{stall: 1'b0, flush: 1'b1};
         de           = '{stall: 1'b0, flush: 1'b1};
         em           = '{stall: 1'b0, flush: 1'b1};
         pc_hold      = 1'b0;
         trap_req     = 1'b0;
         busy_timeout = 1'b0;
      end
   end

   assign any_stall = fd.stall | de.stall | em.stall;

   assign ctrl.pc_hold_o       = pc_hold;
   assign ctrl.fet_dec_stall_o = fd.stall;
   assign ctrl.fet_dec_flush_o = fd.flush;
   assign ctrl.dec_exe_stall_o = de.stall;
   assign ctrl.dec_exe_flush_o = de.flush;
   assign ctrl.exe_mem_stall_o = em.stall;
   assign ctrl.exe_mem_flush_o = em.flush;
   assign ctrl.trap_req_o      = trap_req;
   assign ctrl.busy_timeout_o  = busy_timeout;
   assign ctrl.stall_cycles_o  = perf_cnt_q;

endmodule

// File: tb/tb_beta_pipe_ctrl_unit.sv
// Bench for beta_pipe_ctrl_unit: a cycle-level model of the control rules checked every
// cycle, plus hand-computed spot checks along a directed stimulus sequence.
module tb_beta_pipe_ctrl_unit;
   import beta_pkg::*;

   localparam int TrapLatency   = 3;
   localparam int MaxBusyCycles = 64;
   localparam int PerfWidth     = 32;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   beta_pipe_ctrl_unit_if #(.PerfWidth(PerfWidth)) pif ();

   beta_pipe_ctrl_unit #(
      .TrapLatency   (TrapLatency),
      .MaxBusyCycles (MaxBusyCycles),
      .PerfWidth     (PerfWidth)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .ctrl   (pif)
   );

   typedef struct packed {
      logic       rstn;
      logic       valid;
      logic       is_load;
      logic       invalid;
      logic       branch;
      logic       busy;
      logic       mstall;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
   } stim_t;

   int n_compared   = 0;
   int n_mismatched = 0;
   int cycle        = 0;

   // Model: remaining trap cycles, whether a multi-cycle op is being waited on and how
   // many consecutive busy cycles it has lasted so far.
   bit          m_init = 1'b1;
   int          m_trap_left = 0;
   bit          m_wait = 1'b0;
   int          m_busy_run = 0;
   logic [31:0] m_stalls = '0;
   bit          nx_init = 1'b1;
   int          nx_trap = 0;
   bit          nx_wait = 1'b0;
   int          nx_busy = 0;
   bit          nx_any_stall = 1'b0;

   function automatic stim_t mk(input logic valid, is_load, invalid, branch, busy, mstall,
                                input logic [4:0] rd, rs1, rs2, input logic u1, u2);
      stim_t s;
      s = '{rstn: 1'b1, valid: valid, is_load: is_load, invalid: invalid, branch: branch,
            busy: busy, mstall: mstall, rd: rd, rs1: rs1, rs2: rs2, u1: u1, u2: u2};
      return s;
   endfunction

   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      rstn                    = s.rstn;
      pif.exe_valid_i         = s.valid;
      pif.exe_is_load_i       = s.is_load;
      pif.exe_invalid_instr_i = s.invalid;
      pif.exe_branch_taken_i  = s.branch;
      pif.exe_busy_i          = s.busy;
      pif.mem_stall_i         = s.mstall;
      pif.exe_rd_addr_i       = s.rd;
      pif.dec_rs1_addr_i      = s.rs1;
      pif.dec_rs2_addr_i      = s.rs2;
      pif.dec_rs1_used_i      = s.u1;
      pif.dec_rs2_used_i      = s.u2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Every cycle: derive the required outputs from the rules and compare on the falling edge.
   always @(negedge clk) begin : model_check
      logic       luh, trap_hit, ph, tr, to;
      logic [2:0] st, fl;
      logic [8:0] exp_vec, act_vec;
      st = '0; fl = '0; ph = 1'b0; tr = 1'b0; to = 1'b0;
      nx_init = m_init; nx_trap = m_trap_left; nx_wait = m_wait; nx_busy = m_busy_run;
      luh = pif.exe_valid_i && pif.exe_is_load_i && (pif.exe_rd_addr_i != 5'd0) &&
            ((pif.dec_rs1_used_i && pif.dec_rs1_addr_i == pif.exe_rd_addr_i) ||
             (pif.dec_rs2_used_i && pif.dec_rs2_addr_i == pif.exe_rd_addr_i));
      trap_hit = pif.exe_valid_i && pif.exe_invalid_instr_i;
      if (!rstn) begin
         fl = 3'b111;
         nx_init = 1'b1; nx_trap = 0; nx_wait = 1'b0; nx_busy = 0;
         m_init = 1'b1; m_trap_left = 0; m_wait = 1'b0; m_busy_run = 0;
         m_stalls = '0;
      end else if (m_init) begin
         fl = 3'b111; ph = 1'b1; nx_init = 1'b0;
      end else if (m_trap_left > 0) begin
         fl = 3'b111; nx_trap = m_trap_left - 1;
      end else if (m_wait && pif.mem_stall_i) begin
         st = 3'b111; ph = 1'b1;
      end else if (m_wait && pif.exe_busy_i) begin
         st = 3'b011; fl = 3'b100; ph = 1'b1;
         if (m_busy_run < MaxBusyCycles) begin
            nx_busy = m_busy_run + 1;
            to = (nx_busy == MaxBusyCycles);
         end
      end else begin
         nx_wait = 1'b0; nx_busy = 0;
         if (trap_hit) begin
            fl = 3'b111; tr = 1'b1; nx_trap = TrapLatency;
         end else if (pif.mem_stall_i) begin
            st = 3'b111; ph = 1'b1;
         end else if (pif.exe_branch_taken_i) begin
            fl = 3'b011;
         end else if (!m_wait && pif.exe_busy_i) begin
            st = 3'b011; fl = 3'b100; ph = 1'b1; nx_wait = 1'b1; nx_busy = 1;
         end else if (luh) begin
            st = 3'b001; fl = 3'b010; ph = 1'b1;
         end
      end
      exp_vec = {ph, st[0], fl[0], st[1], fl[1], st[2], fl[2], tr, to};
      act_vec = {pif.pc_hold_o, pif.fet_dec_stall_o, pif.fet_dec_flush_o,
                 pif.dec_exe_stall_o, pif.dec_exe_flush_o, pif.exe_mem_stall_o,
                 pif.exe_mem_flush_o, pif.trap_req_o, pif.busy_timeout_o};
      n_compared++;
      if (act_vec !== exp_vec) begin
         n_mismatched++;
         $display("[TB] FAIL ctrl_vec cycle %0d: got %b, expected %b", cycle, act_vec, exp_vec);
      end
      n_compared++;
      if (pif.stall_cycles_o !== m_stalls) begin
         n_mismatched++;
         $display("[TB] FAIL stall_cycles cycle %0d: got %0d, expected %0d",
                  cycle, pif.stall_cycles_o, m_stalls);
      end
      nx_any_stall = |st;
      cycle++;
   end

   always @(posedge clk) begin
      if (rstn) begin
         m_init      = nx_init;
         m_trap_left = nx_trap;
         m_wait      = nx_wait;
         m_busy_run  = nx_busy;
         if (nx_any_stall) m_stalls = m_stalls + 32'd1;
      end
   end

   stim_t idle, luh_s, busy_s, ms_s;
   stim_t table_s [12];
   int    pulses;

   initial begin
      idle   = mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      luh_s  = mk(1, 1, 0, 0, 0, 0, 5'd5, 5'd0, 5'd5, 0, 1);
      busy_s = mk(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      ms_s   = mk(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
      table_s = '{busy_s,
                  mk(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0),
                  busy_s,
                  mk(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0),
                  busy_s,
                  mk(1, 1, 0, 0, 0, 0, 5'd7, 5'd7, 5'd0, 1, 0),
                  busy_s,
                  mk(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0),
                  idle, idle, idle, idle};

      rstn = 1'b0;
      pif.exe_valid_i = 0; pif.exe_is_load_i = 0; pif.exe_invalid_instr_i = 0;
      pif.exe_branch_taken_i = 0; pif.exe_busy_i = 0; pif.mem_stall_i = 0;
      pif.exe_rd_addr_i = '0; pif.dec_rs1_addr_i = '0; pif.dec_rs2_addr_i = '0;
      pif.dec_rs1_used_i = 0; pif.dec_rs2_used_i = 0;

      #2;
      checkOutput("reset_fd_flush", 32'(pif.fet_dec_flush_o), 32'd1);
      checkOutput("reset_em_flush", 32'(pif.exe_mem_flush_o), 32'd1);
      checkOutput("reset_pc_hold", 32'(pif.pc_hold_o), 32'd0);
      checkOutput("reset_stall_cycles", pif.stall_cycles_o, 32'd0);

      applyStimulus(idle); #3;
      checkOutput("init_pc_hold", 32'(pif.pc_hold_o), 32'd1);
      checkOutput("init_de_flush", 32'(pif.dec_exe_flush_o), 32'd1);
      applyStimulus(idle); #3;
      checkOutput("run_idle_flushes", 32'({pif.fet_dec_flush_o, pif.dec_exe_flush_o,
                  pif.exe_mem_flush_o, pif.pc_hold_o}), 32'd0);
      checkOutput("run_idle_stall_cycles", pif.stall_cycles_o, 32'd0);

      applyStimulus(luh_s); #3;
      checkOutput("luh_fd_stall", 32'(pif.fet_dec_stall_o), 32'd1);
      checkOutput("luh_de_flush", 32'(pif.dec_exe_flush_o), 32'd1);
      checkOutput("luh_pc_hold", 32'(pif.pc_hold_o), 32'd1);
      applyStimulus(mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1)); #3;
      checkOutput("rd0_fd_stall", 32'(pif.fet_dec_stall_o), 32'd0);
      checkOutput("rd0_pc_hold", 32'(pif.pc_hold_o), 32'd0);
      checkOutput("after_luh_stall_cycles", pif.stall_cycles_o, 32'd1);

      applyStimulus(mk(1, 1, 0, 1, 0, 0, 5'd5, 5'd0, 5'd5, 0, 1)); #3;
      checkOutput("br_luh_flushes", 32'({pif.fet_dec_flush_o, pif.dec_exe_flush_o}), 32'd3);
      checkOutput("br_luh_fd_stall", 32'(pif.fet_dec_stall_o), 32'd0);
      checkOutput("br_luh_pc_hold", 32'(pif.pc_hold_o), 32'd0);
      applyStimulus(idle);

      pulses = 0;
      for (int i = 1; i <= 70; i++) begin
         applyStimulus(busy_s); #3;
         if (pif.busy_timeout_o) pulses++;
         if (i == 64) checkOutput("timeout_at_64", 32'(pif.busy_timeout_o), 32'd1);
      end
      checkOutput("timeout_pulses", 32'(pulses), 32'd1);
      applyStimulus(idle); #3;
      checkOutput("busy_drop_pc_hold", 32'(pif.pc_hold_o), 32'd0);
      checkOutput("busy_drop_fd_stall", 32'(pif.fet_dec_stall_o), 32'd0);
      checkOutput("busy_stall_cycles", pif.stall_cycles_o, 32'd71);

      applyStimulus(mk(1, 0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0)); #3;
      checkOutput("trap_req", 32'(pif.trap_req_o), 32'd1);
      checkOutput("trap_em_stall", 32'(pif.exe_mem_stall_o), 32'd0);
      checkOutput("trap_pc_hold", 32'(pif.pc_hold_o), 32'd0);
      for (int i = 1; i <= TrapLatency; i++) begin
         applyStimulus(ms_s); #3;
         checkOutput("trap_hold_req", 32'(pif.trap_req_o), 32'd0);
         checkOutput("trap_hold_flush", 32'(pif.fet_dec_flush_o), 32'd1);
         checkOutput("trap_hold_stall", 32'(pif.fet_dec_stall_o), 32'd0);
      end
      applyStimulus(ms_s); #3;
      checkOutput("post_trap_mstall", 32'(pif.fet_dec_stall_o), 32'd1);
      checkOutput("post_trap_stall_cycles", pif.stall_cycles_o, 32'd71);
      applyStimulus(idle); #3;
      checkOutput("post_mstall_cycles", pif.stall_cycles_o, 32'd72);

      foreach (table_s[i]) applyStimulus(table_s[i]);

      applyStimulus(busy_s);
      applyStimulus(busy_s);
      #2 rstn = 1'b0;
      #1;
      checkOutput("async_rst_flush", 32'(pif.fet_dec_flush_o), 32'd1);
      checkOutput("async_rst_stall", 32'(pif.fet_dec_stall_o), 32'd0);
      checkOutput("async_rst_pc_hold", 32'(pif.pc_hold_o), 32'd0);
      checkOutput("async_rst_cycles", pif.stall_cycles_o, 32'd0);
      applyStimulus('{rstn: 1'b0, default: '0});
      applyStimulus(idle); #3;
      checkOutput("reinit_pc_hold", 32'(pif.pc_hold_o), 32'd1);
      checkOutput("reinit_em_flush", 32'(pif.exe_mem_flush_o), 32'd1);
      applyStimulus(idle); #3;
      checkOutput("rerun_pc_hold", 32'(pif.pc_hold_o), 32'd0);
      checkOutput("rerun_fd_flush", 32'(pif.fet_dec_flush_o), 32'd0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
